// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mlp_pkg
// Brief    : Shared constants and state encoding for the MLP stream loader.
// Revision : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    localparam int IF_WORDS     = 16;
    localparam int W_WORDS      = 1024;
    localparam int B_WORDS      = 64;
    localparam int OUT_PER_PASS = 64;
    localparam int PASS_WORDS   = IF_WORDS + W_WORDS + B_WORDS;
    localparam int BEAT_W       = $clog2(OUT_PER_PASS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACC = 3'd1,
        READY    = 3'd2,
        STREAM   = 3'd3,
        WAIT_OUT = 3'd4,
        FIN      = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/ofmap_capture_buf.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_capture_buf
// Brief    : 64x32 register file, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_capture_buf
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [BEAT_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    input  logic [BEAT_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [OUT_PER_PASS];
    logic [31:0] r_rdata;

    // Storage is intentionally unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mlp_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : mlp_stream_loader
// Brief    : Two-pass ifmap/weight/bias streamer feeding the int8 MLP core.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_stream_loader
    import mlp_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int IFMAP_BASE  = 0,
    parameter int WEIGHT_BASE = 32,
    parameter int BIAS_BASE   = 4128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              acc_done,
    input  logic              acc_valid,
    input  logic [31:0]       acc_ofmap,
    output logic              ready,
    output logic [31:0]       data_in,
    output logic              busy,
    output logic              finished
);

    localparam int c_K_W = $clog2(PASS_WORDS + 1);

    loader_state_t     r_state, w_state_nxt;
    logic              r_mode, r_pass;
    logic [c_K_W-1:0]  r_k;
    logic [BEAT_W-1:0] r_beat_idx;
    logic              r_out_done;
    logic              r_present, r_from_buf;

    logic              w_issue, w_buf_issue;
    logic              w_in_if, w_in_w;
    logic              w_beat, w_last_beat, w_pass_done;
    logic [ADDR_W-1:0] w_addr, w_k_ext, w_k16_ext;
    logic [BEAT_W-1:0] w_bidx;
    logic [31:0]       w_buf_rdata;

    assign w_issue     = (r_state == READY) || ((r_state == STREAM) && (r_k != c_K_W'(PASS_WORDS)));
    assign w_in_if     = r_k < c_K_W'(IF_WORDS);
    assign w_in_w      = !w_in_if && (r_k < c_K_W'(IF_WORDS + W_WORDS));
    assign w_buf_issue = w_issue && !w_in_if && !w_in_w && r_mode && r_pass;

    // Bias phase starts at k=1040, which is 16 modulo 64.
    assign w_bidx    = r_k[BEAT_W-1:0] - BEAT_W'(IF_WORDS);
    assign w_k_ext   = ADDR_W'(r_k);
    assign w_k16_ext = ADDR_W'({r_k[c_K_W-1:4], 4'b0000});

    // Base offsets fold in the phase start so k can be added directly.
    always_comb begin
        w_addr = '0;
        if (w_in_if) begin
            w_addr = ADDR_W'(IFMAP_BASE) + w_k_ext
                   + ((r_pass && r_mode) ? ADDR_W'(IF_WORDS) : '0);
        end else if (w_in_w) begin
            if (r_mode) begin
                w_addr = ADDR_W'(WEIGHT_BASE - 2 * IF_WORDS) + w_k_ext + w_k16_ext
                       + (r_pass ? ADDR_W'(IF_WORDS) : '0);
            end else begin
                w_addr = ADDR_W'(WEIGHT_BASE - IF_WORDS) + w_k_ext
                       + (r_pass ? ADDR_W'(W_WORDS) : '0);
            end
        end else begin
            w_addr = ADDR_W'(BIAS_BASE - IF_WORDS - W_WORDS) + w_k_ext
                   + ((r_pass && !r_mode) ? ADDR_W'(B_WORDS) : '0);
        end
    end

    assign w_beat      = acc_valid && !r_out_done &&
                         ((r_state == READY) || (r_state == STREAM) || (r_state == WAIT_OUT));
    assign w_last_beat = w_beat && (r_beat_idx == BEAT_W'(OUT_PER_PASS - 1));
    assign w_pass_done = r_out_done || w_last_beat;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start) w_state_nxt = WAIT_ACC;
            WAIT_ACC: if (acc_done && !acc_valid) w_state_nxt = READY;
            READY:    w_state_nxt = STREAM;
            STREAM:   if (r_k == c_K_W'(PASS_WORDS)) w_state_nxt = WAIT_OUT;
            WAIT_OUT: if (w_pass_done) w_state_nxt = r_pass ? FIN : WAIT_ACC;
            FIN:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            r_pass     <= 1'b0;
            r_k        <= '0;
            r_beat_idx <= '0;
            r_out_done <= 1'b0;
            r_present  <= 1'b0;
            r_from_buf <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_present  <= w_issue;
            r_from_buf <= w_buf_issue;
            if ((r_state == IDLE) && start) begin
                r_mode <= mode;
                r_pass <= 1'b0;
            end
            if ((r_state == WAIT_OUT) && w_pass_done && !r_pass) begin
                r_pass <= 1'b1;
            end
            if ((r_state == IDLE) || (r_state == WAIT_ACC)) begin
                r_k        <= '0;
                r_beat_idx <= '0;
                r_out_done <= 1'b0;
            end else begin
                if (w_issue) r_k <= r_k + 1'b1;
                if (w_beat) begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                    if (w_last_beat) r_out_done <= 1'b1;
                end
            end
        end
    end

    ofmap_capture_buf u_capture_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_beat && r_mode && !r_pass),
        .i_waddr (r_beat_idx),
        .i_wdata (acc_ofmap),
        .i_re    (w_buf_issue),
        .i_raddr (w_bidx),
        .o_rdata (w_buf_rdata)
    );

    assign mem_ren  = w_issue && !w_buf_issue;
    assign mem_addr = mem_ren ? w_addr : '0;
    assign ready    = (r_state == READY);
    assign finished = (r_state == FIN);
    assign busy     = (r_state != IDLE) && (r_state != FIN);
    assign data_in  = r_present ? (r_from_buf ? w_buf_rdata : mem_rdata) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mlp_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_stream_loader
// Brief    : Directed scoreboard bench for mlp_stream_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_stream_loader;

    localparam int c_ADDR_W = 13;

    logic                clk = 1'b0;
    logic                rst, start, mode;
    logic                mem_ren;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [31:0]         mem_rdata;
    logic                acc_done, acc_valid;
    logic [31:0]         acc_ofmap;
    logic                ready, busy, finished;
    logic [31:0]         data_in;

    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  fin_cnt  = 0;
    logic [31:0]         exp_q[$];

    mlp_stream_loader #(
        .ADDR_W      (c_ADDR_W),
        .IFMAP_BASE  (0),
        .WEIGHT_BASE (32),
        .BIAS_BASE   (4128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .acc_done  (acc_done),
        .acc_valid (acc_valid),
        .acc_ofmap (acc_ofmap),
        .ready     (ready),
        .data_in   (data_in),
        .busy      (busy),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    // Memory holds word == address; unread cycles return a poison value.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? 32'(mem_addr) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (finished === 1'b1) fin_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input bit m, input bit p, input int k);
        int j;
        if (k < 16) return 32'(k + ((p && m) ? 16 : 0));
        if (k < 1040) begin
            j = k - 16;
            if (m) return 32'(32 + j + (j / 16) * 16 + (p ? 16 : 0));
            return 32'(32 + (p ? 1024 : 0) + j);
        end
        j = k - 1040;
        if (!m) return 32'(4128 + (p ? 64 : 0) + j);
        if (!p) return 32'(4128 + j);
        return 32'hA000_0000 + 32'(j);
    endfunction

    task automatic do_start(input bit m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_pass(input bit m, input bit p, input bit chk_lat);
        int w = 0;
        for (int k = 0; k < 1104; k++) exp_q.push_back(exp_word(m, p, k));
        while (ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_seen", 64'(ready), 64'd1);
        if (ready !== 1'b1) begin
            exp_q.delete();
            return;
        end
        if (chk_lat) chk("pass1_ready_latency", 64'(w), 64'd1);
        chk("ren_at_ready", 64'(mem_ren), 64'd1);
        for (int k = 0; k < 1104; k++) begin
            @(negedge clk);
            if (k == 0) chk("ready_one_cycle", 64'(ready), 64'd0);
            chk("data_in", 64'(data_in), 64'(exp_q.pop_front()));
            if (m && p && k >= 1039 && k < 1103) chk("ren_off_bias", 64'(mem_ren), 64'd0);
        end
        @(negedge clk);
        chk("data_after_stream", {mem_ren, data_in}, 64'd0);
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input bit last_pass);
        for (int i = 0; i < n; i++) begin
            acc_valid = 1'b1;
            acc_ofmap = base + 32'(i);
            @(negedge clk);
            if (last_pass && i == 63) chk("finished_pulse", {finished, busy}, 64'b10);
        end
        acc_valid = 1'b0;
        acc_ofmap = 32'd0;
    endtask

    task automatic run_job_body(input bit m, input int n1);
        run_pass(m, 1'b0, 1'b0);
        send_beats(64, m ? 32'hA000_0000 : 32'h5000_0000, 1'b0);
        run_pass(m, 1'b1, 1'b1);
        send_beats(n1, 32'h6000_0000, 1'b1);
    endtask

    initial begin
        int fin0;
        bit seen;
        int w;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        acc_done = 1'b1; acc_valid = 1'b0; acc_ofmap = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {ready, finished, busy, mem_ren, mem_addr, data_in}, 64'd0);
        end

        // Mode 0 job.
        fin0 = fin_cnt;
        do_start(1'b0);
        run_job_body(1'b0, 64);
        repeat (3) @(negedge clk);
        chk("mode0_fin_count", 64'(fin_cnt - fin0), 64'd1);

        // Mode 1 residual job with 70 beats in pass 1.
        fin0 = fin_cnt;
        do_start(1'b1);
        run_job_body(1'b1, 70);
        repeat (3) @(negedge clk);
        chk("extra_beats_fin_count", 64'(fin_cnt - fin0), 64'd1);
        chk("idle_after_extra", 64'(busy), 64'd0);

        // acc_done held low after start: nothing may happen.
        acc_done = 1'b0;
        do_start(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || mem_ren !== 1'b0) seen = 1'b1;
        end
        chk("no_ready_without_done", 64'(seen), 64'd0);
        acc_done = 1'b1;
        fin0 = fin_cnt;
        run_job_body(1'b0, 64);
        repeat (3) @(negedge clk);
        chk("late_done_fin_count", 64'(fin_cnt - fin0), 64'd1);

        // Reset in the middle of pass 0.
        do_start(1'b1);
        w = 0;
        while (ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_abort", 64'(ready), 64'd1);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {ready, finished, busy, mem_ren, mem_addr, data_in}, 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({ready, finished, busy, mem_ren, data_in} !== '0) seen = 1'b1;
        end
        chk("quiet_after_abort", 64'(seen), 64'd0);
        fin0 = fin_cnt;
        do_start(1'b1);
        run_job_body(1'b1, 64);
        repeat (3) @(negedge clk);
        chk("post_abort_fin_count", 64'(fin_cnt - fin0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
